// File: rtl/edge_interval_meter_if.sv
// Result channel of edge_interval_meter: one {level, width, saturated} record per completed phase.
// Latency: none (wires only). Backpressure: valid/ready; the data holds until res_valid && res_ready.
interface edge_interval_meter_if #(
    parameter int CNT_W = 16
);
    logic             res_valid;
    logic             res_ready;
    logic             res_level;
    logic [CNT_W-1:0] res_width;
    logic             res_sat;

    modport master (
        output res_valid,
        output res_level,
        output res_width,
        output res_sat,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_level,
        input  res_width,
        input  res_sat,
        output res_ready
    );
endinterface

// File: rtl/edge_interval_meter.sv
// Times each high/low phase of async sig_in in clk cycles; optional glitch filter under GLITCH_FILTER_EN.
// Latency: result valid 3 cycles after the sig_in edge (plus filter delay when GLITCH_FILTER_EN is defined).
// Backpressure: a capture while a result is still unaccepted is dropped and sets sticky overrun.
module edge_interval_meter #(
    parameter int CNT_W      = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sig_in,
    edge_interval_meter_if.master res,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("edge_interval_meter: FILTER_LEN must be in 2..15");
    end

    logic sync1_q;
    logic sync2_q;
    logic s_sync;
    logic s_f;
    logic s_d_q;
    logic edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_sync = sync2_q;

`ifdef GLITCH_FILTER_EN
    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

    logic       s_f_q;
    logic       s_f_d;
    logic [3:0] flt_cnt_q;
    logic [3:0] flt_cnt_d;

    // flt_cnt counts consecutive cycles s_sync has disagreed with s_f; any agreement restarts it.
    always_comb begin
        s_f_d     = s_f_q;
        flt_cnt_d = 4'd0;
        if (s_sync != s_f_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                s_f_d = s_sync;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_f_q     <= 1'b0;
            flt_cnt_q <= 4'd0;
        end else begin
            s_f_q     <= s_f_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign s_f = s_f_q;
`else
    assign s_f = s_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s_f;
        end
    end

    assign edge_det = s_f ^ s_d_q;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             en_q;
    logic             capture;
    logic             accept;

    logic             vld_q;
    logic             vld_d;
    logic             lvl_q;
    logic             lvl_d;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;
    logic             sat_q;
    logic             sat_d;
    logic             ovr_q;
    logic             ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en;
        end
    end

    // ARM swallows the first edge so the partial phase seen at enable is never reported.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (edge_det) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (edge_det) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                capture = edge_det;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            capture = 1'b0;
        end
    end

    assign accept = vld_q & res.res_ready;

    // Capture in the accept cycle reloads the holding register, so back-to-back results never drop.
    always_comb begin
        vld_d   = vld_q;
        lvl_d   = lvl_q;
        width_d = width_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;

        if (en && !en_q) begin
            ovr_d = 1'b0;
        end

        if (capture) begin
            if (!vld_q || accept) begin
                vld_d   = 1'b1;
                lvl_d   = s_d_q;
                width_d = cnt_q;
                sat_d   = (cnt_q == CNT_MAX);
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            lvl_q   <= 1'b0;
            width_q <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            lvl_q   <= lvl_d;
            width_q <= width_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign res.res_valid = vld_q;
    assign res.res_level = lvl_q;
    assign res.res_width = width_q;
    assign res.res_sat   = sat_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_edge_interval_meter.sv
// Bench for edge_interval_meter: phase tables drive sig_in, a scoreboard checks every accepted result.
// Build with +define+GLITCH_FILTER_EN to exercise the filtered variant.
module tb_edge_interval_meter;

    typedef struct {
        logic lvl;
        int   len;
        bit   chk;
        logic e_lvl;
        int   e_w;
        logic e_sat;
    } ph_t;

    typedef struct {
        logic lvl;
        int   w;
        logic sat;
    } res_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic en     = 1'b0;
    logic sig_in = 1'b0;
    logic ovr;
    logic en4    = 1'b0;
    logic sig4   = 1'b0;
    logic ovr4;

    int n_checks = 0;
    int n_pass   = 0;

    res_t q0[$];
    res_t q1[$];

    edge_interval_meter_if #(.CNT_W(16)) rif ();
    edge_interval_meter_if #(.CNT_W(4))  rif4 ();

    edge_interval_meter #(.CNT_W(16), .FILTER_LEN(3)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sig_in  (sig_in),
        .res     (rif),
        .overrun (ovr)
    );

    edge_interval_meter #(.CNT_W(4), .FILTER_LEN(3)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en4),
        .sig_in  (sig4),
        .res     (rif4),
        .overrun (ovr4)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input int sel, input ph_t p);
        res_t r;
        r.lvl = p.e_lvl;
        r.w   = p.e_w;
        r.sat = p.e_sat;
        if (sel == 0) begin
            sig_in = p.lvl;
            if (p.chk) q0.push_back(r);
        end else begin
            sig4 = p.lvl;
            if (p.chk) q1.push_back(r);
        end
        cyc(p.len);
    endtask

    always @(negedge clk) begin
        if (rst_n && rif.res_valid && rif.res_ready) begin
            res_t e;
            if (q0.size() == 0) begin
                n_checks++;
                $display("FAIL dut16_unexpected: got lvl=%0b w=%0d sat=%0b, expected no result",
                         rif.res_level, rif.res_width, rif.res_sat);
            end else begin
                e = q0.pop_front();
                check("dut16_result", {rif.res_level, rif.res_sat, 30'(rif.res_width)},
                      {e.lvl, e.sat, 30'(e.w)});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rif4.res_valid && rif4.res_ready) begin
            res_t e;
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL dut4_unexpected: got lvl=%0b w=%0d sat=%0b, expected no result",
                         rif4.res_level, rif4.res_width, rif4.res_sat);
            end else begin
                e = q1.pop_front();
                check("dut4_result", {rif4.res_level, rif4.res_sat, 30'(rif4.res_width)},
                      {e.lvl, e.sat, 30'(e.w)});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ph_t t1[4];
        ph_t t2[4];
        ph_t t3[3];
        ph_t t4[12];
        ph_t t5[5];

        t1 = '{'{1'b0, 5, 1'b0, 1'b0, 0, 1'b0},
               '{1'b1, 10, 1'b0, 1'b0, 0, 1'b0},
               '{1'b0, 25, 1'b1, 1'b1, 10, 1'b0},
               '{1'b1, 4, 1'b1, 1'b0, 25, 1'b0}};
        t2 = '{'{1'b0, 8, 1'b0, 1'b0, 0, 1'b0},
               '{1'b1, 8, 1'b1, 1'b0, 8, 1'b0},
               '{1'b0, 8, 1'b0, 1'b0, 0, 1'b0},
               '{1'b1, 30, 1'b0, 1'b0, 0, 1'b0}};
        t3 = '{'{1'b1, 20, 1'b0, 1'b0, 0, 1'b0},
               '{1'b0, 3, 1'b1, 1'b1, 15, 1'b1},
               '{1'b1, 10, 1'b1, 1'b0, 3, 1'b0}};
        for (int i = 0; i < 12; i++) begin
            t4[i].lvl   = (i % 2 == 1);
            t4[i].len   = (i == 11) ? 8 : 1;
            t4[i].chk   = (i > 0);
            t4[i].e_lvl = (i % 2 == 0);
            t4[i].e_w   = 1;
            t4[i].e_sat = 1'b0;
        end
        t5 = '{'{1'b1, 2, 1'b0, 1'b0, 0, 1'b0},
               '{1'b0, 10, 1'b0, 1'b0, 0, 1'b0},
               '{1'b1, 12, 1'b0, 1'b0, 0, 1'b0},
               '{1'b0, 12, 1'b1, 1'b1, 12, 1'b0},
               '{1'b1, 10, 1'b1, 1'b0, 12, 1'b0}};

        rif.res_ready  = 1'b1;
        rif4.res_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(rif.res_valid), 32'd0);
        check("rst_level", 32'(rif.res_level), 32'd0);
        check("rst_width", 32'(rif.res_width), 32'd0);
        check("rst_sat",   32'(rif.res_sat),   32'd0);
        check("rst_ovr",   32'(ovr),           32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Basic measurement; the first low phase is discarded
        en = 1'b1;
        cyc(3);
        for (int i = 0; i < 4; i++) apply(0, t1[i]);
        en = 1'b0;
        cyc(4);
        check("t1_drained", 32'(q0.size()), 32'd0);

        // Overrun with the consumer stalled
        rif.res_ready = 1'b0;
        en = 1'b1;
        cyc(3);
        apply(0, t2[0]);
        apply(0, t2[1]);
        check("t2_valid_a", 32'(rif.res_valid), 32'd1);
        check("t2_width_a", 32'(rif.res_width), 32'd8);
        check("t2_level_a", 32'(rif.res_level), 32'd0);
        check("t2_ovr_a",   32'(ovr),           32'd0);
        apply(0, t2[2]);
        apply(0, t2[3]);
        check("t2_valid_b", 32'(rif.res_valid), 32'd1);
        check("t2_width_b", 32'(rif.res_width), 32'd8);
        check("t2_level_b", 32'(rif.res_level), 32'd0);
        check("t2_ovr_b",   32'(ovr),           32'd1);
        rif.res_ready = 1'b1;
        cyc(3);
        check("t2_valid_c", 32'(rif.res_valid), 32'd0);
        check("t2_ovr_c",   32'(ovr),           32'd1);
        check("t2_drained", 32'(q0.size()),     32'd0);
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(1);
        check("t2_ovr_clr", 32'(ovr), 32'd0);

        // Saturation on the narrow counter
        en4 = 1'b1;
        cyc(3);
        for (int i = 0; i < 3; i++) apply(1, t3[i]);
        en4 = 1'b0;
        cyc(4);
        check("t3_drained", 32'(q1.size()), 32'd0);
        check("t3_ovr",     32'(ovr4),      32'd0);

`ifndef GLITCH_FILTER_EN
        // One-cycle phases back to back: capture and accept in the same cycle
        cyc(3);
        for (int i = 0; i < 12; i++) apply(0, t4[i]);
        en = 1'b0;
        cyc(4);
        check("t4_drained", 32'(q0.size()), 32'd0);
        check("t4_ovr",     32'(ovr),       32'd0);
`else
        // Glitch shorter than FILTER_LEN is ignored
        en = 1'b0;
        sig_in = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(3);
        for (int i = 0; i < 5; i++) apply(0, t5[i]);
        en = 1'b0;
        cyc(4);
        check("t5_drained", 32'(q0.size()), 32'd0);
        check("t5_ovr",     32'(ovr),       32'd0);
`endif

        // Asynchronous reset mid-phase with a pending result
        sig_in = 1'b0;
        rif.res_ready = 1'b0;
        cyc(6);
        en = 1'b1;
        cyc(3);
        apply(0, '{1'b1, 6, 1'b0, 1'b0, 0, 1'b0});
        apply(0, '{1'b0, 7, 1'b0, 1'b0, 0, 1'b0});
        check("t6_valid_pre", 32'(rif.res_valid), 32'd1);
        check("t6_width_pre", 32'(rif.res_width), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_rst", 32'(rif.res_valid), 32'd0);
        check("t6_width_rst", 32'(rif.res_width), 32'd0);
        check("t6_level_rst", 32'(rif.res_level), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        cyc(1);
        rst_n = 1'b1;
        rif.res_ready = 1'b1;
        cyc(3);
        apply(0, '{1'b1, 8, 1'b0, 1'b0, 0, 1'b0});
        check("t6_no_first", 32'(q0.size()), 32'd0);
        sig_in = 1'b0;
        q0.push_back('{1'b1, 8, 1'b0});
`ifndef GLITCH_FILTER_EN
        cyc(2);
        check("t6_lat_early", 32'(rif.res_valid), 32'd0);
        cyc(1);
        check("t6_lat_valid", 32'(rif.res_valid), 32'd1);
        cyc(5);
`else
        cyc(10);
`endif
        en = 1'b0;
        cyc(4);
        check("t6_drained", 32'(q0.size()), 32'd0);
        check("t6_ovr",     32'(ovr),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
